// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_seq
//  Description : Sequential unsigned multiply/divide unit (MULTU / DIVU) with
//                architectural HI/LO registers. One shift-add or restoring
//                shift-subtract step per cycle; 32 steps per operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        mf_req,
  input  logic        hi_lo,
  output logic [31:0] hilo_out,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div0
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_FIN  = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_hi;       // committed HI
  logic [31:0] r_lo;       // committed LO
  logic [31:0] r_acc_hi;   // working: product upper half / partial remainder
  logic [31:0] r_acc_lo;   // working: product lower half / dividend-quotient
  logic [63:0] r_mcand;    // multiplicand, shifted left one place per step
  logic [31:0] r_opb;      // multiplier (shifted right) or divisor (held)
  logic [4:0]  r_cnt;
  logic        r_div0;

  logic        w_last;
  logic [63:0] w_mul_sum;
  logic [32:0] w_rem_sh;
  logic        w_rem_ge;
  logic [31:0] w_rem_sub;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;

  assign w_last    = (r_cnt == 5'd31);

  // Shift-add: add the shifted multiplicand when the current multiplier LSB is set
  assign w_mul_sum = {r_acc_hi, r_acc_lo} + (r_opb[0] ? r_mcand : 64'd0);

  // Restoring division: bring the next dividend bit into the remainder. The
  // 33rd bit keeps the compare exact; after a successful subtract the result
  // is below the divisor, so 32-bit wrapping subtraction is sufficient.
  assign w_rem_sh  = {r_acc_hi, r_acc_lo[31]};
  assign w_rem_ge  = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_sub = w_rem_sh[31:0] - r_opb;
  assign w_rem_nxt = w_rem_ge ? w_rem_sub : w_rem_sh[31:0];
  assign w_quo_nxt = {r_acc_lo[30:0], w_rem_ge};

  assign busy     = (r_state == c_MUL) || (r_state == c_DIV);
  assign done     = (r_state == c_FIN);
  assign div0     = done && r_div0;
  assign stall    = busy && (mf_req || start);
  assign hilo_out = hi_lo ? r_lo : r_hi;

  // Control FSM, working datapath and HI/LO commit
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_mcand  <= 64'd0;
      r_opb    <= 32'd0;
      r_cnt    <= 5'd0;
      r_div0   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_FIN: begin
          if (start) begin
            r_cnt    <= 5'd0;
            r_opb    <= srcb;
            r_mcand  <= {32'd0, srca};
            r_acc_hi <= 32'd0;
            if (op && (srcb == 32'd0)) begin
              // Divide by zero completes immediately with a defined result
              r_state  <= c_FIN;
              r_hi     <= srca;
              r_lo     <= 32'hFFFF_FFFF;
              r_div0   <= 1'b1;
              r_acc_lo <= 32'd0;
            end else if (op) begin
              r_state  <= c_DIV;
              r_div0   <= 1'b0;
              r_acc_lo <= srca;
            end else begin
              r_state  <= c_MUL;
              r_div0   <= 1'b0;
              r_acc_lo <= 32'd0;
            end
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_MUL: begin
          {r_acc_hi, r_acc_lo} <= w_mul_sum;
          r_mcand <= r_mcand << 1;
          r_opb   <= r_opb >> 1;
          r_cnt   <= r_cnt + 5'd1;
          if (w_last) begin
            r_state <= c_FIN;
            r_hi    <= w_mul_sum[63:32];
            r_lo    <= w_mul_sum[31:0];
          end
        end
        c_DIV: begin
          r_acc_hi <= w_rem_nxt;
          r_acc_lo <= w_quo_nxt;
          r_cnt    <= r_cnt + 5'd1;
          if (w_last) begin
            r_state <= c_FIN;
            r_hi    <= w_rem_nxt;
            r_lo    <= w_quo_nxt;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_seq
//  Description : Self-checking bench for mdu_seq: directed scenarios with
//                literal expectations plus randomized traffic compared every
//                cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] srca = 32'd0;
  logic [31:0] srcb = 32'd0;
  logic        mf_req = 1'b0;
  logic        hi_lo = 1'b0;
  logic [31:0] hilo_out;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mdu_seq dut (
    .Clk      (Clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .srca     (srca),
    .srcb     (srcb),
    .mf_req   (mf_req),
    .hi_lo    (hi_lo),
    .hilo_out (hilo_out),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div0     (div0)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: cycles left busy, pending result, committed HI/LO
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_div0 = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;

  always @(posedge Clk) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_div0 <= 1'b0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
    end else if (m_left == 0 && start) begin
      if (op && srcb == 32'd0) begin
        m_left <= 0;
        m_done <= 1'b1;
        m_div0 <= 1'b1;
        m_hi   <= srca;
        m_lo   <= 32'hFFFF_FFFF;
      end else begin
        m_left <= 32;
        m_done <= 1'b0;
        m_div0 <= 1'b0;
        m_pend <= op ? {srca % srcb, srca / srcb}
                     : ({32'd0, srca} * {32'd0, srcb});
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_div0 <= 1'b0;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_hi   <= m_pend[63:32];
        m_lo   <= m_pend[31:0];
      end
    end else begin
      m_done <= 1'b0;
      m_div0 <= 1'b0;
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkint(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge Clk) begin
    if (chk_en) begin
      chk1("busy", busy, m_left != 0);
      chk1("done", done, m_done);
      chk1("div0", div0, m_done && m_div0);
      chk1("stall", stall, (m_left != 0) && (mf_req || start));
      chk32("hilo_out", hilo_out, hi_lo ? m_lo : m_hi);
    end
  end

  // Directed operation: optional ignored start at cycle inj_n, optional
  // MFLO request from cycle mf_n; checks latency and final HI/LO literally.
  task automatic do_op(input string nm, input logic o, input logic [31:0] a,
                       input logic [31:0] b, input int inj_n, input int mf_n,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic exp_d0, input int exp_lat,
                       input logic [31:0] old_lo);
    int n;
    start = 1'b1; op = o; srca = a; srcb = b;
    @(posedge Clk); #1;
    start = 1'b0;
    op = 1'($urandom_range(0, 1)); srca = $urandom; srcb = $urandom;
    n = 1;
    while (!done && n < 100) begin
      if (n == inj_n) begin
        start = 1'b1; op = 1'b1; srcb = 32'd3;
        #1 chk1({nm, "_stall_inj"}, stall, 1'b1);
      end
      if (n == mf_n) begin
        mf_req = 1'b1; hi_lo = 1'b1;
        #1 chk1({nm, "_stall_mf"}, stall, 1'b1);
        chk32({nm, "_old_lo"}, hilo_out, old_lo);
      end
      @(posedge Clk); #1;
      start = 1'b0;
      n++;
    end
    chk1({nm, "_done_seen"}, done, 1'b1);
    chkint({nm, "_latency"}, n, exp_lat);
    chk1({nm, "_div0"}, div0, exp_d0);
    chk1({nm, "_busy_fin"}, busy, 1'b0);
    if (mf_n > 0) begin
      chk1({nm, "_stall_fin"}, stall, 1'b0);
      chk32({nm, "_new_lo"}, hilo_out, exp_lo);
    end
    hi_lo = 1'b0;
    #1 chk32({nm, "_hi"}, hilo_out, exp_hi);
    hi_lo = 1'b1;
    #1 chk32({nm, "_lo"}, hilo_out, exp_lo);
    mf_req = 1'b0;
    chk32({nm, "_model_hi"}, m_hi, exp_hi);
    chk32({nm, "_model_lo"}, m_lo, exp_lo);
    @(posedge Clk); #1;
  endtask

  initial begin
    int n;
    int dones;
    repeat (3) @(posedge Clk);
    #1;
    chk_en = 1'b1;
    reset = 1'b0;
    // Reset state
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_div0", div0, 1'b0);
    hi_lo = 1'b0;
    #1 chk32("rst_hi", hilo_out, 32'd0);
    hi_lo = 1'b1;
    #1 chk32("rst_lo", hilo_out, 32'd0);

    // First edge after reset accepts a start
    do_op("mul_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 32'd0);
    do_op("div_100_7", 1'b1, 32'd100, 32'd7, -1, -1,
          32'd2, 32'd14, 1'b0, 33, 32'd0);
    do_op("div_by0", 1'b1, 32'h1234_5678, 32'd0, -1, -1,
          32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1, 32'd0);
    do_op("mul_3_5", 1'b0, 32'd3, 32'd5, 10, -1,
          32'd0, 32'd15, 1'b0, 33, 32'd0);
    do_op("mul_mf", 1'b0, 32'd1000, 32'd77, -1, 5,
          32'd0, 32'd77000, 1'b0, 33, 32'd15);
    do_op("div_max", 1'b1, 32'hFFFF_FFFF, 32'd1, -1, -1,
          32'd0, 32'hFFFF_FFFF, 1'b0, 33, 32'd0);

    // Reset in the middle of a MULTU 7x9, with a simultaneous start
    start = 1'b1; op = 1'b0; srca = 32'd7; srcb = 32'd9;
    @(posedge Clk); #1;
    start = 1'b0;
    dones = 0;
    n = 1;
    while (n < 16) begin
      @(posedge Clk); #1;
      n++;
      if (done) dones++;
    end
    reset = 1'b1; start = 1'b1; op = 1'b0; srca = 32'd5; srcb = 32'd5;
    @(posedge Clk); #1;
    reset = 1'b0; start = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    hi_lo = 1'b0;
    #1 chk32("abort_hi", hilo_out, 32'd0);
    hi_lo = 1'b1;
    #1 chk32("abort_lo", hilo_out, 32'd0);
    repeat (40) begin
      @(posedge Clk); #1;
      if (done) dones++;
    end
    chkint("abort_no_done", dones, 0);
    do_op("mul_2_2", 1'b0, 32'd2, 32'd2, -1, -1,
          32'd0, 32'd4, 1'b0, 33, 32'd0);

    // Randomized traffic checked by the per-cycle model comparison
    for (int i = 0; i < 3000; i++) begin
      @(posedge Clk); #1;
      reset  = ($urandom_range(0, 299) == 0);
      start  = ($urandom_range(0, 5) == 0);
      op     = 1'($urandom_range(0, 1));
      srca   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 7))
        0:       srcb = 32'd0;
        1:       srcb = 32'($urandom_range(1, 15));
        default: srcb = $urandom;
      endcase
      mf_req = 1'($urandom_range(0, 1));
      hi_lo  = 1'($urandom_range(0, 1));
    end
    @(posedge Clk); #1;
    reset = 1'b0; start = 1'b0;
    repeat (2) @(posedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
